hwag_coil_channel: RTL

Single ignition-coil channel driver that consumes the angle counter and the buffered charge/ignition angles from the angle-generator core. It drives one coil output, for example coil23_out fed by the slave angle counter acnt4.
- Double-buffers the angle pair and only swaps it in at a safe point.
- Handles wrap-around of the angle counter.
- Enforces a maximum-dwell timeout with a sticky fault flag.

---
 rtl/hwag_coil_channel.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hwag_coil_channel.sv
// Single ignition-coil channel: double-buffered charge/ignition angles, wrap-safe equality
// triggering, and a max-dwell timeout. Optional spark counter via HWAG_COIL_SPARK_CNT_EN.
module hwag_coil_channel #(
    parameter int ACNT_WIDTH = 24,
    parameter int ACNT_MAX   = 3839,
    parameter int TMR_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [ACNT_WIDTH-1:0] acnt,
    input  logic                  acnt_step,
    input  logic [ACNT_WIDTH-1:0] charge_angle,
    input  logic [ACNT_WIDTH-1:0] ignition_angle,
    input  logic                  update,
    input  logic [TMR_WIDTH-1:0]  max_dwell,
    input  logic                  fault_clr,
    output logic                  coil_out,
    output logic                  spark,
    output logic                  fault_overdwell,
    output logic                  fault_range,
    output logic                  busy,
    output logic [15:0]           spark_cnt,
    output logic [1:0]            state_dbg
);

    localparam logic [ACNT_WIDTH-1:0] MAX_V = ACNT_WIDTH'(ACNT_MAX);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_CHARGE   = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  coil_q, coil_d;
    logic                  spark_q, spark_d;
    logic                  fault_od_q, fault_od_d;
    logic                  fault_rng_q, fault_rng_d;
    logic [ACNT_WIDTH-1:0] shd_chg_q, shd_chg_d;
    logic [ACNT_WIDTH-1:0] shd_ign_q, shd_ign_d;
    logic [ACNT_WIDTH-1:0] act_chg_q, act_chg_d;
    logic [ACNT_WIDTH-1:0] act_ign_q, act_ign_d;
    logic                  pending_q, pending_d;
    logic [TMR_WIDTH-1:0]  timer_q, timer_d;

    logic upd_ok;
    logic upd_bad;
    logic swap;
    logic hit_chg;
    logic hit_ign;
    logic od_set;

    assign upd_ok  = update & (charge_angle <= MAX_V) & (ignition_angle <= MAX_V);
    assign upd_bad = update & ~upd_ok;
    // Active angles may only change while no dwell is in progress.
    assign swap    = pending_q & ((state_q == ST_IDLE) | (state_q == ST_DISABLED));
    assign hit_chg = acnt_step & (acnt == act_chg_q);
    assign hit_ign = acnt_step & (acnt == act_ign_q);

    always_comb begin
        shd_chg_d = shd_chg_q;
        shd_ign_d = shd_ign_q;
        act_chg_d = act_chg_q;
        act_ign_d = act_ign_q;
        pending_d = pending_q;
        if (swap) begin
            act_chg_d = shd_chg_q;
            act_ign_d = shd_ign_q;
            pending_d = 1'b0;
        end
        // A fresh capture keeps pending set even when the old shadow swaps in this cycle.
        if (upd_ok) begin
            shd_chg_d = charge_angle;
            shd_ign_d = ignition_angle;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        coil_d  = 1'b0;
        spark_d = 1'b0;
        timer_d = timer_q;
        od_set  = 1'b0;
        if (!ena) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (hit_chg && (act_chg_q != act_ign_q)) begin
                        state_d = ST_CHARGE;
                        coil_d  = 1'b1;
                        timer_d = '0;
                    end
                end
                ST_CHARGE: begin
                    coil_d = 1'b1;
                    if (timer_q != '1) timer_d = timer_q + TMR_WIDTH'(1);
                    if (hit_ign) begin
                        state_d = ST_IDLE;
                        coil_d  = 1'b0;
                        spark_d = 1'b1;
                    end else if ((max_dwell != '0) && (timer_q == max_dwell - TMR_WIDTH'(1))) begin
                        state_d = ST_HOLDOFF;
                        coil_d  = 1'b0;
                        od_set  = 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    // Swallow this cycle's ignition so a late spark cannot occur.
                    if (hit_ign) state_d = ST_IDLE;
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    assign fault_od_d  = od_set  ? 1'b1 : (fault_clr ? 1'b0 : fault_od_q);
    assign fault_rng_d = upd_bad ? 1'b1 : (fault_clr ? 1'b0 : fault_rng_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_DISABLED;
            coil_q      <= 1'b0;
            spark_q     <= 1'b0;
            fault_od_q  <= 1'b0;
            fault_rng_q <= 1'b0;
            shd_chg_q   <= '0;
            shd_ign_q   <= '0;
            act_chg_q   <= '0;
            act_ign_q   <= '0;
            pending_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            coil_q      <= coil_d;
            spark_q     <= spark_d;
            fault_od_q  <= fault_od_d;
            fault_rng_q <= fault_rng_d;
            shd_chg_q   <= shd_chg_d;
            shd_ign_q   <= shd_ign_d;
            act_chg_q   <= act_chg_d;
            act_ign_q   <= act_ign_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
        end
    end

`ifdef HWAG_COIL_SPARK_CNT_EN
    logic [15:0] spark_cnt_q, spark_cnt_d;

    always_comb begin
        spark_cnt_d = spark_cnt_q;
        if (fault_clr) spark_cnt_d = '0;
        else if (spark_d && (spark_cnt_q != 16'hFFFF)) spark_cnt_d = spark_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) spark_cnt_q <= '0;
        else     spark_cnt_q <= spark_cnt_d;
    end

    assign spark_cnt = spark_cnt_q;
`else
    assign spark_cnt = 16'd0;
`endif

    assign coil_out        = coil_q;
    assign spark           = spark_q;
    assign fault_overdwell = fault_od_q;
    assign fault_range     = fault_rng_q;
    assign busy            = (state_q == ST_CHARGE) | (state_q == ST_HOLDOFF);
    assign state_dbg       = state_q;

endmodule
